// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response handshake bundle for mem_access_ctrl
`timescale 1ns/1ps
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] rsp_addr;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_addr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_addr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - credit-limited memory request front end with in-order read response FIFO
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_RD_LAT = 1,
  parameter int RSP_DEPTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);
  localparam int TAG_LEN = 1 + MEM_RD_LAT;
  localparam int PW      = $clog2(RSP_DEPTH);
  localparam int OW      = $clog2(RSP_DEPTH + TAG_LEN) + 1;

  logic [TAG_LEN-1:0]    r_tag_v;
  logic [ADDR_WIDTH-1:0] r_tag_a [TAG_LEN];
  logic [DATA_WIDTH-1:0] r_fifo_d [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_a [RSP_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;

  logic [OW-1:0] w_outstanding;
  logic          w_accept;
  logic          w_rd_accept;
  logic          w_push;
  logic          w_pop;

  // Credits cover both reads still in the memory pipeline and responses parked in the FIFO.
  always_comb begin
    w_outstanding = OW'(r_count);
    for (int i = 0; i < TAG_LEN; i++) begin
      w_outstanding = w_outstanding + OW'(r_tag_v[i]);
    end
  end

  assign bus.req_ready = (w_outstanding < OW'(RSP_DEPTH));
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_rd_accept   = w_accept && !bus.req_write;
  assign w_push        = r_tag_v[TAG_LEN-1];
  assign bus.rsp_valid = (r_count != '0);
  assign w_pop         = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_rdata = bus.rsp_valid ? r_fifo_d[r_rd_ptr] : '0;
  assign bus.rsp_addr  = bus.rsp_valid ? r_fifo_a[r_rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      mem_wr_en <= w_accept && bus.req_write;
      mem_rd_en <= w_rd_accept;
      if (w_accept) begin
        mem_addr  <= bus.req_addr;
        mem_wdata <= bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < TAG_LEN; i++) r_tag_a[i] <= '0;
    end else begin
      r_tag_v    <= {r_tag_v[TAG_LEN-2:0], w_rd_accept};
      r_tag_a[0] <= bus.req_addr;
      for (int i = 1; i < TAG_LEN; i++) r_tag_a[i] <= r_tag_a[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_d[r_wr_ptr] <= mem_rdata;
      r_fifo_a[r_wr_ptr] <= r_tag_a[TAG_LEN-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (w_rd_accept && (rd_count != '1))
        rd_count <= rd_count + CNT_WIDTH'(1);
      if (w_accept && bus.req_write && (wr_count != '1))
        wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();
  mem_access_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus2 ();

  logic [2:0]  mem_addr, mem2_addr;
  logic        mem_wr_en, mem_rd_en, mem2_wr_en, mem2_rd_en;
  logic [7:0]  mem_wdata, mem_rdata, mem2_wdata;
  logic [7:0]  mem2_rdata;
  logic [15:0] rd_count, wr_count;
  logic [1:0]  rd_count2, wr_count2;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_access_ctrl #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave),
    .mem_addr(mem2_addr), .mem_wr_en(mem2_wr_en), .mem_rd_en(mem2_rd_en),
    .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata),
    .rd_count(rd_count2), .wr_count(wr_count2)
  );

  assign mem2_rdata = 8'h00;

  // Single-port memory model: registered read, 0xFF after reset.
  logic [7:0] mem [8];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'hFF;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int nxt, got, pulses, idx;
    logic acc, pop, both_seen;
    logic [7:0] hd_d;
    logic [2:0] hd_a;
    logic [7:0] shadow [8];
    logic [10:0] exp_q [$];
    logic [10:0] e;
    logic [1:0] exp6 [5];

    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0; bus2.rsp_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 0);
    chk("rst_counts", {rd_count, wr_count}, 0);

    // Read of addr 3 after reset
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 3'd3;
    tick();
    bus.req_valid = 1'b0;
    chk("t1_rd_en_e0", {29'd0, mem_addr, mem_rd_en, mem_wr_en}, {29'd3, 1'b1, 1'b0});
    chk("t1_rsp_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("t1_rd_en_drop", 32'(mem_rd_en), 0);
    chk("t1_rsp_e1", 32'(bus.rsp_valid), 0);
    tick();
    chk("t1_rsp", {21'd0, bus.rsp_valid, bus.rsp_rdata, bus.rsp_addr}, {21'd0, 1'b1, 8'hFF, 3'd3});
    bus.rsp_ready = 1'b1;
    tick();
    chk("t1_popped", 32'(bus.rsp_valid), 0);

    // Write then read-after-write to addr 5
    do_reset();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd5; bus.req_wdata = 8'hA5;
    tick();
    chk("t2_wr_strobe", {21'd0, mem_wr_en, mem_wdata, mem_addr}, {21'd0, 1'b1, 8'hA5, 3'd5});
    bus.req_write = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("t2_rd_strobe", {30'd0, mem_wr_en, mem_rd_en}, 1);
    tick(); tick();
    chk("t2_raw_data", {23'd0, bus.rsp_valid, bus.rsp_rdata}, {23'd0, 1'b1, 8'hA5});
    chk("t2_counts", {rd_count, wr_count}, {16'd1, 16'd1});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Backpressure: 6 reads with rsp_ready low, only 4 credits
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'(i); bus.req_wdata = 8'(8'h10 + i);
      tick();
    end
    bus.req_write = 1'b0; bus.req_addr = 3'd0;
    nxt = 0; pulses = 0;
    for (int c = 0; c < 10; c++) begin
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (mem_rd_en) pulses++;
      if (acc) nxt++;
      bus.req_addr = 3'(nxt);
    end
    chk("t3_accepted", 32'(nxt), 4);
    chk("t3_rd_pulses", 32'(pulses), 4);
    chk("t3_ready_low", 32'(bus.req_ready), 0);
    chk("t3_head_held", {23'd0, bus.rsp_valid, bus.rsp_rdata}, {23'd0, 1'b1, 8'h10});
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      acc = bus.req_valid && bus.req_ready;
      pop = bus.rsp_valid && bus.rsp_ready;
      hd_d = bus.rsp_rdata; hd_a = bus.rsp_addr;
      tick();
      if (pop) begin
        chk("t3_rsp", {21'd0, hd_d, hd_a}, {21'd0, 8'(8'h10 + got), 3'(got)});
        got++;
      end
      if (acc) nxt++;
      bus.req_addr = 3'(nxt);
      if (nxt >= 6) bus.req_valid = 1'b0;
    end
    chk("t3_rsp_total", 32'(got), 6);
    chk("t3_counts", {rd_count, wr_count}, {16'd6, 16'd6});

    // Streaming mix: write, read, read per address; back-to-back reads push and pop together
    do_reset();
    for (int i = 0; i < 8; i++) shadow[i] = 8'hFF;
    bus.rsp_ready = 1'b1;
    idx = 0; got = 0; both_seen = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd0; bus.req_wdata = 8'h40;
    for (int c = 0; c < 80 && (idx < 18 || exp_q.size() != 0); c++) begin
      acc = bus.req_valid && bus.req_ready;
      pop = bus.rsp_valid && bus.rsp_ready;
      hd_d = bus.rsp_rdata; hd_a = bus.rsp_addr;
      tick();
      if (mem_wr_en && mem_rd_en) both_seen = 1'b1;
      if (pop) begin
        if (exp_q.size() == 0) chk("t4_extra_rsp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("t4_rsp", {21'd0, hd_d, hd_a}, {21'd0, e});
          got++;
        end
      end
      if (acc) begin
        if (bus.req_write) shadow[bus.req_addr] = bus.req_wdata;
        else exp_q.push_back({shadow[bus.req_addr], bus.req_addr});
        idx++;
      end
      if (idx < 18) begin
        bus.req_write = (idx % 3 == 0);
        bus.req_addr  = 3'((idx / 3) * 3 + 1);
        bus.req_wdata = 8'(8'h40 + idx);
      end else bus.req_valid = 1'b0;
    end
    tick(); tick();
    chk("t4_rsp_total", 32'(got), 12);
    chk("t4_drained", {30'd0, bus.rsp_valid, 1'(exp_q.size() != 0)}, 0);
    chk("t4_strobe_excl", 32'(both_seen), 0);
    chk("t4_counts", {rd_count, wr_count}, {16'd12, 16'd6});

    // Reset while 2 reads in flight and 1 response queued
    do_reset();
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 3'd6; bus.req_wdata = 8'h66;
    tick();
    bus.req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr = 3'(i);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("t5_pre_state", {29'd0, bus.rsp_valid, mem_rd_en, bus.req_ready}, 7);
    reset = 1'b1;
    #1;
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t5_rst_counts", {rd_count, wr_count}, 0);
    chk("t5_rst_ready_strobe", {30'd0, bus.req_ready, mem_rd_en}, 2);
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_stale", 32'(bus.rsp_valid), 0);
    bus.req_valid = 1'b1; bus.req_addr = 3'd6;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    chk("t5_reinit_read", {21'd0, bus.rsp_valid, bus.rsp_rdata, bus.rsp_addr}, {21'd0, 1'b1, 8'hFF, 3'd6});

    // Saturating 2-bit write counter
    exp6 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.req_addr = 3'(i);
      tick();
      chk("t6_wr_sat", 32'(wr_count2), 32'(exp6[i]));
    end
    bus2.req_valid = 1'b0;
    chk("t6_rd_zero", 32'(rd_count2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Request-side front end for the single-port synchronous memory (ADDR_WIDTH=3, DATA_WIDTH=8, registered 1-cycle read, contents 0xFF after reset).
- Accepts read/write requests over a valid/ready handshake and drives the memory's addr/wr_en/rd_en/wdata strobes from registers.
- Captures read data and returns it in order through a response FIFO with valid/ready backpressure.
- Keeps saturating read and write operation counters for debug.

Parameters:
- ADDR_WIDTH, 3: memory address width.
- DATA_WIDTH, 8: memory data width.
- MEM_RD_LAT, 1: cycles from the memory sampling rd_en to mem_rdata being valid.
- RSP_DEPTH, 4: response FIFO depth, and the maximum number of outstanding reads (power of 2, at least 2).
- CNT_WIDTH, 16: width of the operation counters.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes the response on an edge where rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_addr  out  ADDR_WIDTH  address of the returned read.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wr_en  out  1  to memory wr_en.
- mem_rd_en  out  1  to memory rd_en.
- mem_wdata  out  DATA_WIDTH  to memory wdata.
- mem_rdata  in  DATA_WIDTH  from memory rdata.
- rd_count  out  CNT_WIDTH  accepted reads, saturating.
- wr_count  out  CNT_WIDTH  accepted writes, saturating.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0 except req_ready, which is 1.
  - Response FIFO is emptied; the in-flight tag pipeline is cleared; counters are cleared.
- Issue stage:
  - On an accept edge E0, mem_addr, mem_wdata, mem_wr_en (req_write) and mem_rd_en (!req_write) are registered.
  - The strobe is high for exactly the one cycle after E0. Memory acts at E1.
  - With no accept, both strobes are 0. mem_addr and mem_wdata hold their last values.
  - mem_wr_en and mem_rd_en are never both 1.
- Read tracking:
  - Each issued read pushes a tag (valid, addr) into a pipeline of length 1+MEM_RD_LAT.
  - When the tag emerges at edge E(1+MEM_RD_LAT), {mem_rdata, addr} is written into the response FIFO.
  - Default timing: accept at E0, capture at E2, rsp_valid high after E2.
  - There is no bypass; every response passes through the FIFO.
- Credit and req_ready:
  - outstanding = in-flight read tags + FIFO occupancy.
  - req_ready = (outstanding < RSP_DEPTH), computed from registered state only. There is no combinational path from rsp_ready or req_valid to req_ready.
  - A FIFO pop frees a credit the cycle after the pop.
  - req_ready applies to writes as well; it does not depend on req_write.
- Ordering:
  - Requests reach the memory strictly in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Responses return in acceptance order.
- Response FIFO:
  - Circular buffer with a wrapping pointer and a count.
  - A push and a pop on the same edge leave the count unchanged.
  - Overflow is impossible by the credit rule.
  - rsp_rdata and rsp_addr show the head entry; they are stable while rsp_valid && !rsp_ready.
- Counters:
  - rd_count and wr_count increment on each accepted read or write.
  - They stick at all-ones and do not wrap.
- Reset mid-operation:
  - In-flight reads and queued responses are discarded; no stale rsp_valid appears after reset.
  - Strobes drop immediately.
  - The memory itself re-initialises to 0xFF.

Test Plan:
- Reset, then read addr 3 -> mem_rd_en one cycle after accept; rsp_valid two cycles after accept with rsp_rdata=0xFF, rsp_addr=3.
- Write addr 5 = 0xA5, then a read of addr 5 on the next cycle -> rsp_rdata=0xA5; wr_count=1, rd_count=1.
- rsp_ready held 0, req_valid held 1 with 6 reads (addrs 0..5) after writing mem[i]=0x10+i -> exactly 4 accepted, then req_ready=0 and no further mem_rd_en. Raise rsp_ready -> responses 0x10..0x13 in order; the remaining 2 reads are accepted afterwards and return 0x14, 0x15.
- rsp_ready=1 with continuous alternating writes/reads, plus simultaneous push and pop -> FIFO count is stable, no response is lost or duplicated, and pointers wrap correctly over at least 12 responses.
- Assert reset while 2 reads are in flight and 1 response is queued -> rsp_valid=0, counters 0, req_ready=1 immediately; a read of any address afterwards returns 0xFF.
- CNT_WIDTH=2, 5 writes -> wr_count sequence 1, 2, 3, 3, 3.
